lcd_16207_sequencer: RTL and testbench

LCD_16207_SEQUENCER -- requirements
Module: lcd_16207_sequencer

---
 rtl/lcd_16207_pkg.sv | 48 ++++
 rtl/lcd_16207_phase_timer.sv | 27 ++
 rtl/lcd_16207_sequencer.sv | 176 +++++++++++++++++
 tb/tb_lcd_16207_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_16207_pkg.sv
// Shared definitions for the 16207 character-LCD sequencer.
// Holds the FSM state type, the Avalon address codes of the LCD slave,
// the power-up instruction ROM and the status-register busy bit.
package lcd_16207_pkg;

  typedef enum logic [3:0] {
    POR_WAIT,
    INIT_CMD,
    INIT_GAP,
    IDLE,
    WR_SETUP,
    WR_STROBE,
    WR_HOLD,
    RD_SETUP,
    RD_STROBE,
    RD_HOLD,
    POLL_CHECK
  } state_t;

  localparam logic [1:0] ADDR_CMD_WR    = 2'd0;
  localparam logic [1:0] ADDR_STATUS_RD = 2'd1;
  localparam logic [1:0] ADDR_DATA_WR   = 2'd2;

  localparam int BUSY_BIT = 7;

  localparam logic [7:0] INIT_FUNCTION_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] INIT_DISPLAY_ON   = 8'h0C;  // display on, cursor off
  localparam logic [7:0] INIT_CLEAR        = 8'h01;
  localparam logic [7:0] INIT_ENTRY_MODE   = 8'h06;  // increment, no shift

  localparam int INIT_LEN       = 6;
  localparam int INIT_GAP_COUNT = 3;  // leading ROM entries issued blind (busy flag not yet valid)

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1, 3'd2: init_rom = INIT_FUNCTION_SET;
      3'd3:             init_rom = INIT_DISPLAY_ON;
      3'd4:             init_rom = INIT_CLEAR;
      3'd5:             init_rom = INIT_ENTRY_MODE;
      default:          init_rom = 8'h00;
    endcase
  endfunction

  function automatic int max_int(input int a, input int b);
    max_int = (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_16207_phase_timer.sv
// Interval timer for the sequencer phases (POR, gap, setup, strobe, hold).
// Counts up from zero while count is high; done is asserted while the count
// equals the terminal value, so a phase lasts term+1 cycles. load restarts
// the count at zero.
// Ports: clk, reset (sync, active high), load, count, term[W-1:0], done.
module lcd_16207_phase_timer #(
  parameter int W = 20
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         count,
  input  logic [W-1:0] term,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)      cnt <= '0;
    else if (load)  cnt <= '0;
    else if (count) cnt <= cnt + 1'b1;
  end

  assign done = (cnt == term);

endmodule

// File: rtl/lcd_16207_sequencer.sv
// Byte-stream to 16207 LCD Avalon slave sequencer.
// After the power-on wait it replays the init ROM, then accepts bytes on a
// valid/ready interface and turns each into an instruction or data write
// followed by busy-flag polling of the status register.
// Ports:
//   clk, reset                 clock, sync active-high reset
//   in_valid/in_ready          byte handshake; in_data byte, in_is_cmd selects RS
//   avm_*                      Avalon master towards the LCD slave
//   init_done                  init ROM fully issued and acknowledged
//   poll_timeout               sticky, set when busy polling gave up
//
// state      | meaning
// POR_WAIT   | power-on delay after reset
// INIT_CMD   | load next init ROM byte onto the bus
// INIT_GAP   | blind wait after the first three init writes
// IDLE       | ready for a byte (only once init_done)
// WR_SETUP   | address/data stable before write strobe
// WR_STROBE  | avm_write high
// WR_HOLD    | address/data stable after write strobe
// RD_SETUP   | status address stable before read strobe
// RD_STROBE  | avm_read high, status captured on last cycle
// RD_HOLD    | status address stable after read strobe
// POLL_CHECK | decide re-poll / next init step / idle
module lcd_16207_sequencer
  import lcd_16207_pkg::*;
#(
  parameter int POR_WAIT_CYCLES = 750000,
  parameter int SETUP_CYCLES    = 3,
  parameter int E_CYCLES        = 12,
  parameter int HOLD_CYCLES     = 3,
  parameter int INIT_GAP_CYCLES = 250000,
  parameter int MAX_POLLS       = 4096
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_is_cmd,
  output logic [1:0] avm_address,
  output logic       avm_write,
  output logic       avm_read,
  output logic       avm_begintransfer,
  output logic [7:0] avm_writedata,
  input  logic [7:0] avm_readdata,
  output logic       init_done,
  output logic       poll_timeout
);

  localparam int TMAX = max_int(max_int(max_int(POR_WAIT_CYCLES, SETUP_CYCLES),
                                        max_int(E_CYCLES, HOLD_CYCLES)),
                                INIT_GAP_CYCLES);
  localparam int TW = $clog2(TMAX + 1);
  localparam int PW = $clog2(MAX_POLLS + 1);

  state_t          state;
  logic [2:0]      rom_idx;
  logic [PW-1:0]   poll_cnt;
  logic [7:0]      status;
  logic [TW-1:0]   term;
  logic            timed;
  logic            t_done;
  logic            last_poll;
  logic            unused_status;

  assign unused_status = ^status[6:0];

  always_comb begin
    term  = '0;
    timed = 1'b1;
    case (state)
      POR_WAIT:              term = TW'(POR_WAIT_CYCLES - 1);
      INIT_GAP:              term = TW'(INIT_GAP_CYCLES - 1);
      WR_SETUP, RD_SETUP:    term = TW'(SETUP_CYCLES - 1);
      WR_STROBE, RD_STROBE:  term = TW'(E_CYCLES - 1);
      WR_HOLD, RD_HOLD:      term = TW'(HOLD_CYCLES - 1);
      default:               timed = 1'b0;
    endcase
  end

  // Untimed states keep the timer parked at zero so every timed phase
  // starts from a fresh count.
  lcd_16207_phase_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (!timed || t_done),
    .count (timed && !t_done),
    .term  (term),
    .done  (t_done)
  );

  // This reading is the MAX_POLLS-th consecutive busy one if it is busy.
  assign last_poll = (poll_cnt == PW'(MAX_POLLS - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= POR_WAIT;
      rom_idx           <= '0;
      poll_cnt          <= '0;
      status            <= '0;
      avm_address       <= ADDR_CMD_WR;
      avm_write         <= 1'b0;
      avm_read          <= 1'b0;
      avm_begintransfer <= 1'b0;
      avm_writedata     <= 8'h00;
      in_ready          <= 1'b0;
      init_done         <= 1'b0;
      poll_timeout      <= 1'b0;
    end else begin
      avm_begintransfer <= 1'b0;
      case (state)
        POR_WAIT: if (t_done) state <= INIT_CMD;
        INIT_CMD: begin
          avm_address   <= ADDR_CMD_WR;
          avm_writedata <= init_rom(rom_idx);
          rom_idx       <= rom_idx + 3'd1;
          state         <= WR_SETUP;
        end
        INIT_GAP: if (t_done) state <= INIT_CMD;
        IDLE: if (in_valid && in_ready) begin
          avm_address   <= in_is_cmd ? ADDR_CMD_WR : ADDR_DATA_WR;
          avm_writedata <= in_data;
          in_ready      <= 1'b0;
          state         <= WR_SETUP;
        end
        WR_SETUP: if (t_done) begin
          avm_write         <= 1'b1;
          avm_begintransfer <= 1'b1;
          state             <= WR_STROBE;
        end
        WR_STROBE: if (t_done) begin
          avm_write <= 1'b0;
          state     <= WR_HOLD;
        end
        WR_HOLD: if (t_done) begin
          // rom_idx has already advanced past the byte just written
          if (!init_done && rom_idx <= 3'(INIT_GAP_COUNT)) begin
            state <= INIT_GAP;
          end else begin
            avm_address <= ADDR_STATUS_RD;
            state       <= RD_SETUP;
          end
        end
        RD_SETUP: if (t_done) begin
          avm_read          <= 1'b1;
          avm_begintransfer <= 1'b1;
          state             <= RD_STROBE;
        end
        RD_STROBE: if (t_done) begin
          avm_read <= 1'b0;
          status   <= avm_readdata;
          state    <= RD_HOLD;
        end
        RD_HOLD: if (t_done) state <= POLL_CHECK;
        POLL_CHECK: begin
          if (status[BUSY_BIT] && !last_poll) begin
            poll_cnt <= poll_cnt + 1'b1;
            state    <= RD_SETUP;
          end else begin
            if (status[BUSY_BIT]) poll_timeout <= 1'b1;
            poll_cnt <= '0;
            if (init_done || rom_idx == 3'(INIT_LEN)) begin
              init_done <= 1'b1;
              in_ready  <= 1'b1;
              state     <= IDLE;
            end else begin
              state <= INIT_CMD;
            end
          end
        end
        default: state <= POR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_16207_sequencer.sv
module tb_lcd_16207_sequencer;

  localparam int POR   = 20;
  localparam int SETUP = 2;
  localparam int E     = 4;
  localparam int HOLD  = 2;
  localparam int GAP   = 10;
  localparam int MAXP  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       in_is_cmd = 1'b0;
  logic [1:0] avm_address;
  logic       avm_write, avm_read, avm_begintransfer;
  logic [7:0] avm_writedata, avm_readdata;
  logic       init_done, poll_timeout;

  always #5 clk = ~clk;

  lcd_16207_sequencer #(
    .POR_WAIT_CYCLES (POR),
    .SETUP_CYCLES    (SETUP),
    .E_CYCLES        (E),
    .HOLD_CYCLES     (HOLD),
    .INIT_GAP_CYCLES (GAP),
    .MAX_POLLS       (MAXP)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .in_valid          (in_valid),
    .in_ready          (in_ready),
    .in_data           (in_data),
    .in_is_cmd         (in_is_cmd),
    .avm_address       (avm_address),
    .avm_write         (avm_write),
    .avm_read          (avm_read),
    .avm_begintransfer (avm_begintransfer),
    .avm_writedata     (avm_writedata),
    .avm_readdata      (avm_readdata),
    .init_done         (init_done),
    .poll_timeout      (poll_timeout)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    tests++;
    if (act < lo || act > hi) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  function automatic int pack(input int w, input int a, input int d);
    return (w << 16) | (a << 8) | d;
  endfunction

  // LCD status model: the next busy_target reads after rd_base report busy.
  int rd_count = 0;
  int rd_base = 0;
  int busy_target = 0;
  assign avm_readdata = ((rd_count - rd_base) < busy_target) ? 8'h80 : 8'h00;

  // Bus monitor: one event per strobe, plus protocol violation counters.
  typedef struct {
    bit is_wr;
    int addr;
    int data;
    int len;
    int start;
  } ev_t;

  ev_t evq[$];
  int  cyc = 0;
  bit  pw = 1'b0, pr = 1'b0, strobe, prev;
  int  slen = 0, sstart = 0, saddr = 0, sdata = 0;
  int  hold_left = 0;
  logic [1:0] ha [4];
  logic [7:0] hd [4];
  int  ov_viol = 0, bt_viol = 0, su_viol = 0, ho_viol = 0, rdy_viol = 0;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      pw = 1'b0;
      pr = 1'b0;
      hold_left = 0;
      slen = 0;
    end else begin
      strobe = avm_write || avm_read;
      prev   = pw || pr;
      if (avm_write && avm_read) ov_viol++;
      if (avm_begintransfer != (strobe && !prev)) bt_viol++;
      if (in_ready && !init_done) rdy_viol++;
      if (hold_left > 0) begin
        if (int'(avm_address) != saddr || int'(avm_writedata) != sdata) ho_viol++;
        hold_left--;
      end
      if (strobe && !prev) begin
        sstart = cyc;
        slen   = 0;
        saddr  = int'(avm_address);
        sdata  = int'(avm_writedata);
        for (int i = 0; i < SETUP; i++)
          if (ha[i] != avm_address || hd[i] != avm_writedata) su_viol++;
      end
      if (strobe) begin
        slen++;
        if (int'(avm_address) != saddr || int'(avm_writedata) != sdata) su_viol++;
      end
      if (!strobe && prev) begin
        evq.push_back('{pw, saddr, sdata, slen, sstart});
        if (pr) rd_count++;
        if (int'(avm_address) != saddr || int'(avm_writedata) != sdata) ho_viol++;
        hold_left = HOLD - 1;
      end
      pw = avm_write;
      pr = avm_read;
    end
    for (int i = 3; i > 0; i--) begin
      ha[i] = ha[i-1];
      hd[i] = hd[i-1];
    end
    ha[0] = avm_address;
    hd[0] = avm_writedata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_init(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (init_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Holds in_valid until the byte is taken; returns at posedge+1 after the transfer.
  task automatic send_byte(input logic [7:0] d, input bit c, output bit ok);
    tick();
    in_data   = d;
    in_is_cmd = c;
    in_valid  = 1'b1;
    wait_ready(ok);
    tick();
    in_valid = 1'b0;
  endtask

  int rom [6] = '{32'h38, 32'h38, 32'h38, 32'h0C, 32'h01, 32'h06};

  task automatic check_init(input int rel);
    bit ok;
    int exp_ev[$];
    int n, last;
    wait_init(ok);
    check("init_done_set", int'(ok), 1);
    check("in_ready_at_init", int'(in_ready), 1);
    for (int k = 0; k < 6; k++) begin
      exp_ev.push_back(pack(1, 0, rom[k]));
      if (k >= 3) exp_ev.push_back(pack(0, 1, rom[k]));
    end
    check("init_event_count", evq.size(), exp_ev.size());
    n = (evq.size() < exp_ev.size()) ? evq.size() : exp_ev.size();
    for (int i = 0; i < n; i++) begin
      check("init_event", pack(int'(evq[i].is_wr), evq[i].addr, evq[i].data), exp_ev[i]);
      check("init_strobe_len", evq[i].len, E);
    end
    if (n >= 4) begin
      check_range("por_delay", evq[0].start - rel, POR + SETUP, POR + SETUP + 2);
      for (int i = 0; i < 3; i++) begin
        last = evq[i].start + evq[i].len - 1;
        check_range("init_gap", evq[i+1].start - last, HOLD + GAP + SETUP + 1, HOLD + GAP + SETUP + 3);
      end
    end
  endtask

  task automatic verify_events(input int d, input int addr, input int polls);
    int good = 0;
    check("evq_size", evq.size(), 1 + polls);
    if (evq.size() >= 1) begin
      check("wr_kind", int'(evq[0].is_wr), 1);
      check("wr_addr", evq[0].addr, addr);
      check("wr_data", evq[0].data, d);
      check("wr_len", evq[0].len, E);
    end
    for (int i = 1; i < evq.size(); i++)
      if (!evq[i].is_wr && evq[i].addr == 1 && evq[i].len == E && evq[i].data == d) good++;
    check("polls_ok", good, polls);
  endtask

  task automatic run_txn(input logic [7:0] d, input bit c, input int busy,
                         input int exp_addr, input int exp_polls, input int exp_to);
    bit ok;
    rd_base     = rd_count;
    busy_target = busy;
    evq.delete();
    send_byte(d, c, ok);
    check("accepted", int'(ok), 1);
    wait_ready(ok);
    check("back_to_idle", int'(ok), 1);
    verify_events(int'(d), exp_addr, exp_polls);
    check("poll_timeout", int'(poll_timeout), exp_to);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         is_cmd;
    int         busy;
    int         exp_addr;
    int         exp_polls;
    int         exp_to;
  } vec_t;

  vec_t vt [6];

  initial begin
    bit ok;
    int rel, acc_reads, to_model, busy, polls;
    logic [7:0] d;
    bit c;

    vt[0] = '{8'h41, 1'b0, 0,  2, 1, 0};
    vt[1] = '{8'h01, 1'b1, 3,  0, 4, 0};
    vt[2] = '{8'h55, 1'b0, 7,  2, 8, 0};
    vt[3] = '{8'hAA, 1'b1, 8,  0, 8, 1};
    vt[4] = '{8'h42, 1'b0, 0,  2, 1, 1};
    vt[5] = '{8'hFF, 1'b0, 20, 2, 8, 1};

    reset = 1'b1;
    repeat (3) tick();
    check("rst_write", int'(avm_write), 0);
    check("rst_read", int'(avm_read), 0);
    check("rst_bt", int'(avm_begintransfer), 0);
    check("rst_addr", int'(avm_address), 0);
    check("rst_wdata", int'(avm_writedata), 0);
    check("rst_ready", int'(in_ready), 0);
    check("rst_init_done", int'(init_done), 0);
    check("rst_timeout", int'(poll_timeout), 0);
    reset = 1'b0;
    rel = cyc + 1;
    evq.delete();
    check_init(rel);

    for (int i = 0; i < 6; i++)
      run_txn(vt[i].data, vt[i].is_cmd, vt[i].busy, vt[i].exp_addr, vt[i].exp_polls, vt[i].exp_to);

    // Reset in the middle of a write strobe
    rd_base = rd_count;
    busy_target = 0;
    send_byte(8'h5A, 1'b0, ok);
    check("rst_txn_accepted", int'(ok), 1);
    ok = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (avm_write) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_strobe_seen", int'(ok), 1);
    tick();
    reset = 1'b1;
    tick();
    check("midrst_write", int'(avm_write), 0);
    check("midrst_init_done", int'(init_done), 0);
    check("midrst_ready", int'(in_ready), 0);
    check("midrst_timeout", int'(poll_timeout), 0);
    tick();
    reset = 1'b0;
    rel = cyc + 1;
    evq.delete();
    check_init(rel);

    // Back-to-back bytes; the second waits through four polls of the first
    rd_base = rd_count;
    busy_target = 3;
    evq.delete();
    send_byte(8'h01, 1'b1, ok);
    check("b2b_first_acc", int'(ok), 1);
    send_byte(8'h48, 1'b0, ok);
    check("b2b_second_acc", int'(ok), 1);
    acc_reads = rd_count - rd_base;
    check("b2b_reads_before_accept", acc_reads, 4);
    wait_ready(ok);
    check("b2b_idle", int'(ok), 1);
    check("b2b_evq_size", evq.size(), 7);
    if (evq.size() == 7) begin
      check("b2b_w1", pack(int'(evq[0].is_wr), evq[0].addr, evq[0].data), pack(1, 0, 8'h01));
      for (int i = 1; i < 5; i++)
        check("b2b_poll1", pack(int'(evq[i].is_wr), evq[i].addr, evq[i].data), pack(0, 1, 8'h01));
      check("b2b_w2", pack(int'(evq[5].is_wr), evq[5].addr, evq[5].data), pack(1, 2, 8'h48));
      check("b2b_poll2", pack(int'(evq[6].is_wr), evq[6].addr, evq[6].data), pack(0, 1, 8'h48));
      check("b2b_order", int'(evq[5].start > evq[4].start + evq[4].len), 1);
    end

    // Randomized traffic against the transaction-level model
    to_model = 0;
    for (int i = 0; i < 16; i++) begin
      d     = 8'($urandom_range(0, 255));
      c     = 1'($urandom_range(0, 1));
      busy  = int'($urandom_range(0, 10));
      polls = (busy + 1 > MAXP) ? MAXP : busy + 1;
      if (busy >= MAXP) to_model = 1;
      run_txn(d, c, busy, c ? 0 : 2, polls, to_model);
    end

    check("no_rw_overlap", ov_viol, 0);
    check("begintransfer_ok", bt_viol, 0);
    check("setup_stable", su_viol, 0);
    check("hold_stable", ho_viol, 0);
    check("ready_only_after_init", rdy_viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
